// File: rtl/cpu_loader_pkg.sv
// ---------------------------------------------------------------------------
// cpu_loader_pkg
// Shared types and constants for the boot loader: the FSM state encoding,
// the command bytes recognised on the serial stream, and the helper that
// turns a word index into a byte address.
// ---------------------------------------------------------------------------
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        RUN    = 3'd5
    } state_t;

    localparam logic [7:0] CMD_IMEM = 8'h49;  // 'I'
    localparam logic [7:0] CMD_DMEM = 8'h44;  // 'D'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

    // Word index -> 32-bit byte address (zero-extended, times four).
    function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
        return {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// ---------------------------------------------------------------------------
// loader_word_packer
// Packs a big-endian byte stream into 32-bit words.
// Ports:
//   clk        clock
//   clr        synchronous clear of the shift register and byte counter
//   byte_valid a byte is being consumed this cycle
//   byte_in    the byte being consumed
//   word_valid high in the cycle the 4th byte of a word is consumed
//   word       the completed word (valid together with word_valid); it
//              already includes byte_in so the consumer can register it on
//              the same edge that consumes the last byte
// ---------------------------------------------------------------------------
module loader_word_packer (
    input  logic        clk,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [31:0] shift_r;
    logic [1:0]  cnt_r;

    // Shift register and byte counter; clear has priority over a new byte.
    always_ff @(posedge clk) begin
        if (clr) begin
            shift_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (byte_valid) begin
            shift_r <= {shift_r[23:0], byte_in};
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign word_valid = byte_valid && (cnt_r == 2'd3);
    assign word       = {shift_r[23:0], byte_in};

endmodule

// File: rtl/cpu_loader.sv
// ---------------------------------------------------------------------------
// cpu_loader
// Boot loader in front of the cpu. Parses a byte stream of commands:
//   'I' / 'D' + 16-bit count + count*4 bytes -> writes words to imem / dmem
//   'G' -> raises cpu_enable,  'H' (while running) -> drops it again.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready     byte stream handshake
//   addr_ext/wen_ext/ren_ext/wdata_ext         instruction-memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 data-memory port
//   cpu_enable                    processor run enable
//   busy                          loader is inside a command
//   done / err                    one-cycle block complete / rejected pulses
// All outputs except the constant read strobes come straight from flops.
// ---------------------------------------------------------------------------
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state_r;
    logic        sel_dmem_r;
    logic [15:0] count_r;
    logic [15:0] word_idx_r;

    logic        rx_ready_r;
    logic [31:0] addr_ext_r;
    logic        wen_ext_r;
    logic [31:0] wdata_ext_r;
    logic [31:0] addr_ext_2_r;
    logic        wen_ext_2_r;
    logic [31:0] wdata_ext_2_r;
    logic        cpu_enable_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;

    logic        rx_fire_s;
    logic [15:0] cnt_s;
    logic [16:0] depth_s;
    logic        pk_byte_valid_s;
    logic        pk_clr_s;
    logic        pk_word_valid_s;
    logic [31:0] pk_word_s;

    assign rx_fire_s       = rx_valid && rx_ready_r;
    // Full count as it will be once the low byte is consumed in CNT_LO.
    assign cnt_s           = {count_r[15:8], rx_data};
    assign depth_s         = sel_dmem_r ? 17'(DMEM_WORDS) : 17'(IMEM_WORDS);
    assign pk_byte_valid_s = rx_fire_s && (state_r == DATA);
    // Leaving DATA only happens on the word-completing byte.
    assign pk_clr_s        = rst || ((state_r == DATA) && pk_word_valid_s);

    loader_word_packer u_packer (
        .clk        (clk),
        .clr        (pk_clr_s),
        .byte_valid (pk_byte_valid_s),
        .byte_in    (rx_data),
        .word_valid (pk_word_valid_s),
        .word       (pk_word_s)
    );

    // Loader FSM with count/index registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            sel_dmem_r    <= 1'b0;
            count_r       <= 16'd0;
            word_idx_r    <= 16'd0;
            rx_ready_r    <= 1'b1;
            addr_ext_r    <= 32'd0;
            wen_ext_r     <= 1'b0;
            wdata_ext_r   <= 32'd0;
            addr_ext_2_r  <= 32'd0;
            wen_ext_2_r   <= 1'b0;
            wdata_ext_2_r <= 32'd0;
            cpu_enable_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            // Strobes and pulses last one cycle unless re-asserted below.
            wen_ext_r   <= 1'b0;
            wen_ext_2_r <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (rx_fire_s) begin
                        case (rx_data)
                            CMD_IMEM: begin
                                sel_dmem_r <= 1'b0;
                                state_r    <= CNT_HI;
                                busy_r     <= 1'b1;
                            end
                            CMD_DMEM: begin
                                sel_dmem_r <= 1'b1;
                                state_r    <= CNT_HI;
                                busy_r     <= 1'b1;
                            end
                            CMD_GO: begin
                                state_r      <= RUN;
                                cpu_enable_r <= 1'b1;
                            end
                            default: begin
                                err_r <= 1'b1;
                            end
                        endcase
                    end
                end

                CNT_HI: begin
                    if (rx_fire_s) begin
                        count_r[15:8] <= rx_data;
                        state_r       <= CNT_LO;
                    end
                end

                CNT_LO: begin
                    if (rx_fire_s) begin
                        count_r    <= cnt_s;
                        word_idx_r <= 16'd0;
                        if (cnt_s == 16'd0) begin
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else if ({1'b0, cnt_s} > depth_s) begin
                            err_r   <= 1'b1;
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end

                DATA: begin
                    // The strobe is registered on the edge that consumes the
                    // 4th byte so it is visible in the following (WRITE) cycle.
                    if (pk_word_valid_s) begin
                        state_r    <= WRITE;
                        rx_ready_r <= 1'b0;
                        if (sel_dmem_r) begin
                            wen_ext_2_r   <= 1'b1;
                            addr_ext_2_r  <= word_byte_addr(word_idx_r);
                            wdata_ext_2_r <= pk_word_s;
                        end else begin
                            wen_ext_r   <= 1'b1;
                            addr_ext_r  <= word_byte_addr(word_idx_r);
                            wdata_ext_r <= pk_word_s;
                        end
                        word_idx_r <= word_idx_r + 16'd1;
                        // done rides along with the last strobe.
                        if ((word_idx_r + 16'd1) == count_r) begin
                            done_r <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    rx_ready_r <= 1'b1;
                    if (word_idx_r == count_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= DATA;
                    end
                end

                RUN: begin
                    // Everything except HALT is swallowed while running.
                    if (rx_fire_s && (rx_data == CMD_HALT)) begin
                        cpu_enable_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end

                default: begin
                    state_r      <= IDLE;
                    rx_ready_r   <= 1'b1;
                    cpu_enable_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready    = rx_ready_r;
    assign addr_ext    = addr_ext_r;
    assign wen_ext     = wen_ext_r;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_ext_r;
    assign addr_ext_2  = addr_ext_2_r;
    assign wen_ext_2   = wen_ext_2_r;
    assign ren_ext_2   = 1'b0;
    assign wdata_ext_2 = wdata_ext_2_r;
    assign cpu_enable  = cpu_enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_cpu_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_loader
// Directed stimulus for cpu_loader. Expected memory writes and done/err
// pulses are queued before the bytes that cause them are sent; a monitor
// on the falling edge pops one expectation per observed event.
// Event kinds: 0 imem write, 1 dmem write, 2 done without write, 3 err.
// ---------------------------------------------------------------------------
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cpu_loader #(
        .IMEM_WORDS (512),
        .DMEM_WORDS (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic        dn;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t sb_q[$];
    ev_t mon_o;
    ev_t mon_e;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  last_stall = 0;

    logic [31:0] dwords [8] = '{32'hA0B1C200, 32'hA1B1C201, 32'hA2B1C202, 32'hA3B1C203,
                                32'hA4B1C204, 32'hA5B1C205, 32'hA6B1C206, 32'hA7B1C207};

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic dn,
                             input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.dn   = dn;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Present a byte at a falling edge and return at the falling edge after
    // the rising edge that consumed it; last_stall = cycles rx_ready was low.
    task automatic send(input logic [7:0] b);
        int waits = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted within 20 cycles", b);
        end
        last_stall = waits;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every write strobe / done / err is one event.
    always @(negedge clk) begin
        if (!rst && (wen_ext || wen_ext_2 || done || err)) begin
            mon_o.dn = done;
            if (wen_ext) begin
                mon_o.kind = 2'd0; mon_o.addr = addr_ext;   mon_o.data = wdata_ext;
            end else if (wen_ext_2) begin
                mon_o.kind = 2'd1; mon_o.addr = addr_ext_2; mon_o.data = wdata_ext_2;
            end else if (err) begin
                mon_o.kind = 2'd3; mon_o.addr = 32'd0;      mon_o.data = 32'd0;
            end else begin
                mon_o.kind = 2'd2; mon_o.addr = 32'd0;      mon_o.data = 32'd0;
            end
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no event", mon_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_event", 67'(mon_o), 67'(mon_e));
            end
            chk("done_err_excl", 67'(done && err), 67'd0);
            chk("single_wen", 67'(wen_ext && wen_ext_2), 67'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask;
        logic [31:0] w;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_addr",  67'({addr_ext, addr_ext_2}), 67'd0);
        chk("rst_wdata", 67'({wdata_ext, wdata_ext_2}), 67'd0);
        chk("rst_ctrl",  67'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable,
                              busy, done, err, rx_ready}), 67'h001);

        // Two-word instruction load
        expect_ev(2'd0, 1'b0, 32'h0, 32'hDEADBEEF);
        expect_ev(2'd0, 1'b1, 32'h4, 32'h0000002A);
        send(8'h49); send(8'h00); send(8'h02);
        chk("i_busy", 67'(busy), 67'd1);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("i_wen_latency", 67'({wen_ext, rx_ready}), 67'b10);
        send(8'h00); send(8'h00); send(8'h00); send(8'h2A);
        idle(2);
        chk("i_idle_busy", 67'(busy), 67'd0);

        // Zero count, then a bad command byte
        expect_ev(2'd2, 1'b1, 32'h0, 32'h0);
        send(8'h49); send(8'h00); send(8'h00);
        chk("zero_busy", 67'(busy), 67'd0);
        expect_ev(2'd3, 1'b0, 32'h0, 32'h0);
        send(8'h00);
        idle(1);

        // Oversize data load, next byte G starts RUN
        expect_ev(2'd3, 1'b0, 32'h0, 32'h0);
        send(8'h44); send(8'h04); send(8'h01);
        chk("over_busy", 67'(busy), 67'd0);
        send(8'h47);
        chk("go_enable", 67'({cpu_enable, busy}), 67'b10);
        send(8'h49);
        chk("run_discard", 67'({cpu_enable, busy}), 67'b10);
        send(8'h48);
        chk("halt_enable", 67'({cpu_enable, busy}), 67'b00);
        expect_ev(2'd3, 1'b0, 32'h0, 32'h0);
        send(8'h00);
        idle(1);

        // Eight-word data load with rx_valid held high throughout
        for (int i = 0; i < 8; i++) begin
            expect_ev(2'd1, (i == 7), 32'(i * 4), dwords[i]);
        end
        send(8'h44); send(8'h00); send(8'h08);
        mask = 32'd0;
        for (int wi = 0; wi < 8; wi++) begin
            w = dwords[wi];
            for (int bi = 0; bi < 4; bi++) begin
                send(w[31 - 8 * bi -: 8]);
                if (last_stall != 0) mask[wi * 4 + bi] = 1'b1;
            end
        end
        idle(2);
        chk("bp_mask", 67'(mask), 67'h11111110);
        chk("imem_hold", 67'({addr_ext, wdata_ext}), 67'({32'h4, 32'h0000002A}));

        // Reset in the middle of a word
        send(8'h49); send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_addr",  67'({addr_ext, addr_ext_2}), 67'd0);
        chk("mid_rst_wdata", 67'({wdata_ext, wdata_ext_2}), 67'd0);
        chk("mid_rst_ctrl",  67'({wen_ext, wen_ext_2, cpu_enable, busy, done, err, rx_ready}),
            67'h01);
        expect_ev(2'd0, 1'b1, 32'h0, 32'h11223344);
        send(8'h49); send(8'h00); send(8'h01);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);

        // Reset while running
        send(8'h47);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("run_rst_enable", 67'(cpu_enable), 67'd0);
        idle(2);

        chk("sb_empty", 67'(sb_q.size()), 67'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
